servo_pwm_bank: RTL and testbench
=================================

// Module: servo_pwm_bank
// PURPOSE
//  Multi-channel hobby-servo PWM generator, driven by the follower/motor control logic.
//  Per channel: 8-bit position command -> pulse width inside a fixed frame, optional enable,
//  optional slew limiting.
//  Commands arrive over a valid/ready write port. They apply only at frame boundaries,
//  so no pulse is ever truncated or stretched.
// PARAMETERS
//  CLK_HZ     100_000_000  system clock frequency
//  PERIOD_US  20_000       frame period in us
//  MIN_US     1_000        pulse width for cmd_pos=0
//  MAX_US     2_000        nominal pulse width for cmd_pos=max
//  N_CH       2            number of servo channels (>=1)
//  CMD_W      8            position command width
//  SLEW_CYC   0            max change of applied width per frame, in clk cycles; 0 = no limit
//  Derived:
//   PERIOD_CYC = CLK_HZ/1e6*PERIOD_US (2,000,000); CNT_W = $clog2(PERIOD_CYC)
//   MIN_CYC = 100,000; STEP_CYC = (MAX_CYC-MIN_CYC)/(2**CMD_W-1), integer-truncated (392)
//   CH_W = max(1,$clog2(N_CH))
// PORTS
//  clk        in   1        system clock
//  rst        in   1        asynchronous reset, active low
//  cmd_valid  in   1        command write request
//  cmd_ready  out  1        write accepted when cmd_valid && cmd_ready
//  cmd_ch     in   CH_W     target channel
//  cmd_pos    in   CMD_W    position command
//  cmd_en     in   1        1 = channel pulses, 0 = channel held low
//  cmd_err    out  1        1-cycle pulse: accepted command had cmd_ch >= N_CH
//  frame_tick out  1        1-cycle pulse on the first cycle of each frame
//  servo      out  N_CH     PWM outputs, one bit per channel
// BEHAVIOUR
//  Reset (rst=0, async)
//   - servo=0, cmd_ready=0, cmd_err=0, frame_tick=0, counter=0
//   - per channel: en_pend=en_act=0; tgt = cur = MID_CYC = MIN_CYC + STEP_CYC*2**(CMD_W-1) (150,176)
//   - All registers are registered outputs. cmd_ready rises on the first clk edge after rst releases.
//  Frame counter
//   - counts 0..PERIOD_CYC-1, then wraps to 0
//   - The cycle with counter==PERIOD_CYC-1 is the UPDATE cycle.
//  Write port
//   - cmd_ready=0 exactly during the UPDATE cycle, 1 otherwise (out of reset)
//   - On accept with cmd_ch<N_CH: tgt[ch] <= MIN_CYC + cmd_pos*STEP_CYC; en_pend[ch] <= cmd_en.
//   - Accepts are one per cycle. Multiple writes to the same channel in one frame: last wins.
//   - cmd_ch>=N_CH: accepted, no state change, cmd_err=1 on the next cycle.
//   - cmd_valid may stay high across the UPDATE cycle; it is accepted on the following cycle.
//  UPDATE cycle, all channels in parallel
//   - en_act <= en_pend
//   - SLEW_CYC==0 or |tgt-cur|<=SLEW_CYC: cur <= tgt
//   - otherwise cur <= cur +/- SLEW_CYC, toward tgt
//   - Arithmetic is unsigned, CNT_W bits. No overflow is possible, since tgt <= MAX_CYC < PERIOD_CYC.
//  Outputs
//   - servo[i] <= en_act[i] && (counter < cur[i]), registered, 1 cycle behind counter
//   - Result: high for exactly cur[i] cycles per frame, aligned to frame start.
//   - frame_tick <= (counter==0), aligned with the first high cycle of servo.
//   - A disabled channel is low for the whole frame. Enable/disable takes effect at the next frame only.
//  Reset mid-frame or mid-pulse
//   - Outputs drop immediately. Pending commands are lost.
//   - After release the first frame starts from counter=0.
// TESTING
//  1 Reset: assert rst=0 mid-pulse -> servo=0 same cycle. Release -> cmd_ready=1 after 1 clk;
//    servo stays 0 (channels disabled).
//  2 Write ch0 pos=0 en=1, SLEW_CYC=0 -> next frame servo[0] high exactly 100,000 cycles;
//    frame_tick period 2,000,000.
//  3 pos=255 -> 199,960 high cycles; pos=128 -> 150,176. ch1 untouched stays low.
//  4 SLEW_CYC=5000, ch0 en from reset, pos=255 -> widths 155,176, 160,176 ... 195,176,
//    then 199,960 (10 frames), then steady.
//  5 Hold cmd_valid through the UPDATE cycle -> cmd_ready=0 that cycle, accept next cycle.
//    cmd_ch=2 with N_CH=2 -> cmd_err 1-cycle pulse, all widths unchanged.
//  6 Two writes to ch0 in one frame (pos 10, then 200) -> next frame width 178,400.
//    Write en=0 -> servo[0] low from the following frame start.

Source files
------------

// File: rtl/servo_pwm_bank.sv
// Multi-channel hobby-servo PWM bank. Each channel pulses high for cur[i] cycles
// at the start of every frame. Commands arrive on a valid/ready port and take
// effect only at the frame boundary (UPDATE cycle), optionally slew-limited.
module servo_pwm_bank #(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned PERIOD_US = 20_000,
    parameter int unsigned MIN_US    = 1_000,
    parameter int unsigned MAX_US    = 2_000,
    parameter int unsigned N_CH      = 2,
    parameter int unsigned CMD_W     = 8,
    parameter int unsigned SLEW_CYC  = 0,
    localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CH_W-1:0]  cmd_ch,
    input  logic [CMD_W-1:0] cmd_pos,
    input  logic             cmd_en,
    output logic             cmd_err,
    output logic             frame_tick,
    output logic [N_CH-1:0]  servo
);

    localparam int unsigned CYC_PER_US = CLK_HZ / 1_000_000;
    localparam int unsigned PERIOD_CYC = CYC_PER_US * PERIOD_US;
    localparam int unsigned CNT_W      = $clog2(PERIOD_CYC);
    localparam int unsigned MIN_CYC    = CYC_PER_US * MIN_US;
    localparam int unsigned MAX_CYC    = CYC_PER_US * MAX_US;
    localparam int unsigned STEP_CYC   = (MAX_CYC - MIN_CYC) / ((2 ** CMD_W) - 1);
    localparam int unsigned MID_CYC    = MIN_CYC + STEP_CYC * (2 ** (CMD_W - 1));

    localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(PERIOD_CYC - 1);
    localparam logic [CNT_W-1:0] C_PRELAST = CNT_W'(PERIOD_CYC - 2);
    localparam logic [CNT_W-1:0] C_MIN     = CNT_W'(MIN_CYC);
    localparam logic [CNT_W-1:0] C_STEP    = CNT_W'(STEP_CYC);
    localparam logic [CNT_W-1:0] C_MID     = CNT_W'(MID_CYC);
    localparam logic [CNT_W-1:0] C_SLEW    = CNT_W'(SLEW_CYC);

    logic [CNT_W-1:0] r_cnt;
    logic             r_ready;
    logic             r_err;
    logic             r_tick;
    logic [N_CH-1:0]  r_servo;
    logic [N_CH-1:0]  r_en_pend;
    logic [N_CH-1:0]  r_en_act;
    logic [CNT_W-1:0] r_tgt [N_CH];
    logic [CNT_W-1:0] r_cur [N_CH];
    logic [CNT_W-1:0] w_cur_nxt [N_CH];
    logic [CNT_W-1:0] w_cmd_tgt;
    logic             w_update;
    logic             w_accept;
    logic             w_ch_bad;

    assign w_update  = (r_cnt == C_LAST);
    assign w_accept  = cmd_valid && r_ready;
    assign w_ch_bad  = (32'(cmd_ch) >= N_CH);
    assign w_cmd_tgt = C_MIN + CNT_W'(cmd_pos) * C_STEP;

    assign cmd_ready  = r_ready;
    assign cmd_err    = r_err;
    assign frame_tick = r_tick;
    assign servo      = r_servo;

    // Frame counter: 0..PERIOD_CYC-1, wrapping after the UPDATE cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_update) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Registered status strobes; ready is dropped one cycle early so it is low exactly in UPDATE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ready <= 1'b0;
            r_tick  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= (r_cnt != C_PRELAST);
            r_tick  <= (r_cnt == '0);
            r_err   <= w_accept && w_ch_bad;
        end
    end

    // Next applied width per channel: jump to target, or step toward it by at most SLEW_CYC
    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            w_cur_nxt[i] = r_tgt[i];
            if (SLEW_CYC != 0) begin
                if ((r_tgt[i] > r_cur[i]) && ((r_tgt[i] - r_cur[i]) > C_SLEW)) begin
                    w_cur_nxt[i] = r_cur[i] + C_SLEW;
                end else if ((r_cur[i] > r_tgt[i]) && ((r_cur[i] - r_tgt[i]) > C_SLEW)) begin
                    w_cur_nxt[i] = r_cur[i] - C_SLEW;
                end
            end
        end
    end

    // Channel state: commands land in pending/target, UPDATE moves them to the active set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_en_pend <= '0;
            r_en_act  <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_tgt[i] <= C_MID;
                r_cur[i] <= C_MID;
            end
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (w_accept && (cmd_ch == CH_W'(i))) begin
                    r_tgt[i]     <= w_cmd_tgt;
                    r_en_pend[i] <= cmd_en;
                end
                if (w_update) begin
                    r_en_act[i] <= r_en_pend[i];
                    r_cur[i]    <= w_cur_nxt[i];
                end
            end
        end
    end

    // PWM outputs, one cycle behind the counter so they line up with frame_tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_servo <= '0;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_servo[i] <= r_en_act[i] && (r_cnt < r_cur[i]);
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Bench for servo_pwm_bank: two scaled-down instances (no slew / slew=50, 2 / 3 channels)
// checked frame by frame against a frame-level reference model.
module tb_servo_pwm_bank;

    localparam int P     = 1000;  // frame length in cycles (1 MHz clock, 1000 us)
    localparam int MINC  = 100;
    localparam int STEP  = 3;     // (865-100)/255
    localparam int MIDC  = 484;   // 100 + 3*128
    localparam int MAXW  = 865;   // 100 + 255*3

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic       v0 = 1'b0, en0 = 1'b0;
    logic [0:0] ch0 = '0;
    logic [7:0] pos0 = '0;
    logic       rdy0, err0, tick0;
    logic [1:0] servo0;

    logic       v1 = 1'b0, en1 = 1'b0;
    logic [1:0] ch1 = '0;
    logic [7:0] pos1 = '0;
    logic       rdy1, err1, tick1;
    logic [2:0] servo1;

    always #5 clk = ~clk;

    servo_pwm_bank #(.CLK_HZ(1_000_000), .PERIOD_US(1000), .MIN_US(100), .MAX_US(865),
                     .N_CH(2), .CMD_W(8), .SLEW_CYC(0)) u_dut0 (
        .clk(clk), .rst(rst), .cmd_valid(v0), .cmd_ready(rdy0), .cmd_ch(ch0),
        .cmd_pos(pos0), .cmd_en(en0), .cmd_err(err0), .frame_tick(tick0), .servo(servo0));

    servo_pwm_bank #(.CLK_HZ(1_000_000), .PERIOD_US(1000), .MIN_US(100), .MAX_US(865),
                     .N_CH(3), .CMD_W(8), .SLEW_CYC(50)) u_dut1 (
        .clk(clk), .rst(rst), .cmd_valid(v1), .cmd_ready(rdy1), .cmd_ch(ch1),
        .cmd_pos(pos1), .cmd_en(en1), .cmd_err(err1), .frame_tick(tick1), .servo(servo1));

    int total = 0;
    int bad   = 0;
    int nch  [2] = '{2, 3};
    int slew [2] = '{0, 50};

    // frame-level model
    int m_tgt [2][3];
    int m_cur [2][3];
    bit m_pend [2][3];
    bit m_act  [2][3];
    int pexp [2][3];   // expected width of the frame that just ended
    int cexp [2][3];   // expected width of the frame now running

    // monitor results
    int frame_cnt = 0;
    int cyc       = 0;
    int period    = 0;
    int run_w  [2][3];
    int done_w [2][3];
    bit run_ok [2][3];
    bit done_ok [2][3];
    bit seen_low [2][3];

    function automatic logic sv(int i, int c);
        if (i == 0) begin
            case (c)
                0: return servo0[0];
                default: return servo0[1];
            endcase
        end
        case (c)
            0: return servo1[0];
            1: return servo1[1];
            default: return servo1[2];
        endcase
    endfunction

    // Measures the high width of every channel per frame and whether it is one leading run
    always @(negedge clk) begin
        if (!rst) begin
            frame_cnt = 0;
            cyc = 0;
            for (int i = 0; i < 2; i++)
                for (int c = 0; c < 3; c++) begin
                    run_w[i][c] = 0; run_ok[i][c] = 1'b1; seen_low[i][c] = 1'b0;
                end
        end else if (tick0) begin
            period = cyc;
            cyc = 1;
            frame_cnt++;
            for (int i = 0; i < 2; i++)
                for (int c = 0; c < nch[i]; c++) begin
                    done_w[i][c]  = run_w[i][c];
                    done_ok[i][c] = run_ok[i][c];
                    run_w[i][c]   = sv(i, c) ? 1 : 0;
                    run_ok[i][c]  = 1'b1;
                    seen_low[i][c] = !sv(i, c);
                end
        end else begin
            cyc++;
            for (int i = 0; i < 2; i++)
                for (int c = 0; c < nch[i]; c++) begin
                    if (sv(i, c)) begin
                        if (seen_low[i][c]) run_ok[i][c] = 1'b0;
                        run_w[i][c]++;
                    end else begin
                        seen_low[i][c] = 1'b1;
                    end
                end
        end
    end

    function automatic void model_reset();
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < 3; c++) begin
                m_tgt[i][c] = MIDC; m_cur[i][c] = MIDC;
                m_pend[i][c] = 1'b0; m_act[i][c] = 1'b0;
                pexp[i][c] = 0; cexp[i][c] = 0;
            end
    endfunction

    function automatic void model_write(int i, int c, int pos, bit en);
        if (c < nch[i]) begin
            m_tgt[i][c]  = MINC + pos * STEP;
            m_pend[i][c] = en;
        end
    endfunction

    function automatic void model_boundary();
        int d;
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < nch[i]; c++) begin
                m_act[i][c] = m_pend[i][c];
                d = m_tgt[i][c] - m_cur[i][c];
                if (slew[i] == 0 || (d <= slew[i] && -d <= slew[i])) m_cur[i][c] = m_tgt[i][c];
                else if (d > 0) m_cur[i][c] = m_cur[i][c] + slew[i];
                else m_cur[i][c] = m_cur[i][c] - slew[i];
                pexp[i][c] = cexp[i][c];
                cexp[i][c] = m_act[i][c] ? m_cur[i][c] : 0;
            end
    endfunction

    // Wait for the next frame start, then advance the model across the boundary
    task automatic wait_frame();
        int f0 = frame_cnt;
        int k = 0;
        while (frame_cnt == f0 && k < P + 20) begin
            @(negedge clk); #1;
            k++;
        end
        if (frame_cnt == f0) begin
            total++; bad++;
            $display("FAIL frame_timeout: no frame_tick within %0d cycles, want one", P + 20);
        end
        model_boundary();
    endtask

    task automatic do_write(int i, int c, int pos, bit en);
        bit acc = 1'b0;
        int k = 0;
        if (i == 0) begin v0 = 1'b1; ch0 = 1'(c); pos0 = 8'(pos); en0 = en; end
        else        begin v1 = 1'b1; ch1 = 2'(c); pos1 = 8'(pos); en1 = en; end
        while (!acc && k < 10) begin
            acc = (i == 0) ? rdy0 : rdy1;
            @(posedge clk);
            @(negedge clk); #1;
            k++;
        end
        v0 = 1'b0; v1 = 1'b0;
        if (!acc) begin
            total++; bad++;
            $display("FAIL write_accept inst%0d: cmd_ready=0 for 10 cycles, want 1", i);
        end else begin
            model_write(i, c, pos, en);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({rdy0, rdy1, err0, err1, tick0, tick1, servo0, servo1} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %b, want all 0",
                     {rdy0, rdy1, err0, err1, tick0, tick1, servo0, servo1});
        end
        model_reset();
        rst = 1'b1;
        total++;
        if (rdy0 !== 1'b0) begin bad++; $display("FAIL ready_before_edge: got %b want 0", rdy0); end
        @(posedge clk); #1;
        total++;
        if ({rdy0, rdy1} !== 2'b11) begin
            bad++; $display("FAIL ready_after_release: got %b want 11", {rdy0, rdy1});
        end
        @(negedge clk); #1;
        wait_frame();
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < nch[i]; c++) begin
                total++;
                if (done_w[i][c] !== 0) begin
                    bad++; $display("FAIL reset_idle inst%0d ch%0d: width %0d want 0", i, c, done_w[i][c]);
                end
            end
        total++;
        if (period !== P) begin bad++; $display("FAIL tick_period: got %0d want %0d", period, P); end
    endtask

    // write positions to both instances, then check the frame after the boundary
    task automatic test_width(int pos, int want0);
        do_write(0, 0, pos, 1'b1);
        do_write(1, 0, pos, 1'b1);
        wait_frame();
        wait_frame();
        total++;
        if (done_w[0][0] !== want0 || done_ok[0][0] !== 1'b1) begin
            bad++; $display("FAIL width_pos%0d: got %0d (contig %0b) want %0d", pos, done_w[0][0], done_ok[0][0], want0);
        end
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < nch[i]; c++) begin
                total++;
                if (done_w[i][c] !== pexp[i][c] || done_ok[i][c] !== 1'b1) begin
                    bad++; $display("FAIL model_width inst%0d ch%0d: got %0d (contig %0b) want %0d",
                                    i, c, done_w[i][c], done_ok[i][c], pexp[i][c]);
                end
            end
        total++;
        if (period !== P || tick1 !== tick0) begin
            bad++; $display("FAIL tick_period: got %0d want %0d", period, P);
        end
    endtask

    task automatic test_slew();
        int want;
        do_write(1, 1, 255, 1'b1);
        wait_frame();
        for (int k = 1; k <= 9; k++) begin
            wait_frame();
            want = (MIDC + 50 * k > MAXW) ? MAXW : MIDC + 50 * k;
            total++;
            if (done_w[1][1] !== want || done_w[1][1] !== pexp[1][1] || done_ok[1][1] !== 1'b1) begin
                bad++; $display("FAIL slew_frame%0d: got %0d want %0d", k, done_w[1][1], want);
            end
        end
    endtask

    task automatic test_update_hold();
        int k = 0;
        int f0;
        while (cyc != P - 1 && k < 2 * P) begin @(negedge clk); #1; k++; end
        f0 = frame_cnt;
        total++;
        if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin
            bad++; $display("FAIL ready_in_update: got %b want 00", {rdy0, rdy1});
        end
        v0 = 1'b1; ch0 = 1'b1; pos0 = 8'd7; en0 = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        total++;
        if (rdy0 !== 1'b1) begin bad++; $display("FAIL ready_after_update: got %b want 1", rdy0); end
        @(posedge clk); @(negedge clk); #1;
        v0 = 1'b0;
        total++;
        if (frame_cnt !== f0 + 1) begin
            bad++; $display("FAIL hold_frame_pos: frame count %0d want %0d", frame_cnt, f0 + 1);
        end
        model_boundary();
        model_write(0, 1, 7, 1'b1);
        // out-of-range channel on the 3-channel instance
        v1 = 1'b1; ch1 = 2'd3; pos1 = 8'd0; en1 = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        v1 = 1'b0;
        total++;
        if (err1 !== 1'b1) begin bad++; $display("FAIL cmd_err_pulse: got %b want 1", err1); end
        @(negedge clk); #1;
        total++;
        if (err1 !== 1'b0 || err0 !== 1'b0) begin
            bad++; $display("FAIL cmd_err_clear: got %b want 00", {err0, err1});
        end
        for (int f = 0; f < 2; f++) begin
            wait_frame();
            for (int i = 0; i < 2; i++)
                for (int c = 0; c < nch[i]; c++) begin
                    total++;
                    if (done_w[i][c] !== pexp[i][c] || done_ok[i][c] !== 1'b1) begin
                        bad++; $display("FAIL hold_width inst%0d ch%0d: got %0d want %0d",
                                        i, c, done_w[i][c], pexp[i][c]);
                    end
                end
        end
        total++;
        if (done_w[0][1] !== MINC + 7 * STEP) begin
            bad++; $display("FAIL held_cmd_width: got %0d want %0d", done_w[0][1], MINC + 7 * STEP);
        end
    endtask

    task automatic test_last_wins();
        do_write(0, 0, 10, 1'b1);
        do_write(0, 0, 200, 1'b1);
        wait_frame();
        wait_frame();
        total++;
        if (done_w[0][0] !== 700 || pexp[0][0] !== 700) begin
            bad++; $display("FAIL last_wins: got %0d want 700", done_w[0][0]);
        end
        do_write(0, 0, 200, 1'b0);
        wait_frame();
        total++;
        if (done_w[0][0] !== 700) begin bad++; $display("FAIL disable_late: got %0d want 700", done_w[0][0]); end
        wait_frame();
        total++;
        if (done_w[0][0] !== 0) begin bad++; $display("FAIL disable: got %0d want 0", done_w[0][0]); end
    endtask

    task automatic test_random();
        int n, c;
        for (int f = 0; f < 16; f++) begin
            for (int i = 0; i < 2; i++) begin
                n = $urandom_range(0, 3);
                for (int w = 0; w < n; w++) begin
                    c = (i == 0) ? $urandom_range(0, 1) : $urandom_range(0, 3);
                    do_write(i, c, $urandom_range(0, 255), ($urandom_range(0, 3) != 0));
                end
            end
            wait_frame();
            for (int i = 0; i < 2; i++)
                for (int ch = 0; ch < nch[i]; ch++) begin
                    total++;
                    if (done_w[i][ch] !== pexp[i][ch] || done_ok[i][ch] !== 1'b1) begin
                        bad++; $display("FAIL rand_width f%0d inst%0d ch%0d: got %0d (contig %0b) want %0d",
                                        f, i, ch, done_w[i][ch], done_ok[i][ch], pexp[i][ch]);
                    end
                end
        end
    endtask

    task automatic test_mid_reset();
        int k = 0;
        do_write(0, 0, 255, 1'b1);
        wait_frame();
        wait_frame();
        do_write(1, 2, 100, 1'b1);   // pending only; must be lost by reset
        while (cyc != 50 && k < 2 * P) begin @(negedge clk); #1; k++; end
        total++;
        if (servo0[0] !== 1'b1) begin bad++; $display("FAIL pre_reset_high: got %b want 1", servo0[0]); end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({servo0, servo1, rdy0, rdy1} !== '0) begin
            bad++; $display("FAIL async_reset: got %b want 0", {servo0, servo1, rdy0, rdy1});
        end
        @(negedge clk); #1;
        rst = 1'b1;
        model_reset();
        wait_frame();
        wait_frame();
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < nch[i]; c++) begin
                total++;
                if (done_w[i][c] !== 0) begin
                    bad++; $display("FAIL after_reset inst%0d ch%0d: got %0d want 0", i, c, done_w[i][c]);
                end
            end
        total++;
        if (period !== P) begin bad++; $display("FAIL reset_period: got %0d want %0d", period, P); end
    endtask

    initial begin
        test_reset();
        test_width(0, MINC);
        test_width(255, MAXW);
        test_width(128, MIDC);
        test_slew();
        test_update_hold();
        test_last_wins();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
